light_fault_monitor: RTL and testbench
======================================

Name: light_fault_monitor

Overview:
- Downstream of the traffic controller FSM. Consumes its four 3-bit approach light vectors (M1, S, M2, MT) and registers them onto the lamp-driver outputs.
- Passes lights through only when they are well-formed, conflict-free, correctly sequenced and not stuck.
- On any violation it latches a fault and forces all approaches to flashing red.
- An operator clear runs an all-red interval before pass-through resumes.

Parameters:
- MAX_ON_CYC, 60, max consecutive non-red cycles per approach before a stuck fault (1 cycle = 1 s at system clock).
- FLASH_HALF, 1, cycles per on/off half-period of flashing red.
- ALLRED_CYC, 3, solid all-red cycles in recovery before pass-through resumes.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- light_M1  in  3  controller light, main road dir 1.
- light_S  in  3  controller light, side road.
- light_M2  in  3  controller light, main road dir 2.
- light_MT  in  3  controller light, main-road turn.
- fault_clr  in  1  operator clear pulse; sampled only in FLASH.
- drv_M1, drv_S, drv_M2, drv_MT  out  3 each  registered lamp drives.
- fault  out  1  high in FLASH and RECOVER.
- fault_code  out  3  first-detected fault cause, held until clear.

Behaviour:
- Encoding: bit2 = red, bit1 = yellow, bit0 = green.
  - Valid values: 100, 010, 001.
  - 000 is dark, used only by the flash output.
- Reset (rst = 0, async):
  - state = PASS, all drv = 100, fault = 0, fault_code = 0.
  - Watchdog counters = 0; previous-light registers = 100.
- PASS: the checks below run combinationally on the raw inputs each cycle.
  - If all pass, each drv takes its input at the next edge (latency 1 cycle). Previous-light registers update to the inputs.
  - If any fails, at the next edge all drv = 100, state = FLASH, fault = 1, and fault_code takes the lowest-numbered failing code. The failing input never reaches drv.
- Fault codes, in priority order:
  - 1 = invalid encoding: any input not one-hot.
  - 2 = conflict. A light is active if it is not red. Conflict when:
    - S is active together with any of M1/M2/MT; or
    - M2 and MT are both active.
    - Legal active sets: {M1, M2}, {M1, MT}, {S}, {M1}, {M2}, {MT}, none.
  - 3 = sequence, against the previous value:
    - legal: hold, G→Y, Y→R, R→G;
    - illegal: G→R, Y→G, R→Y.
  - 4 = stuck: an approach's consecutive-active counter reaches MAX_ON_CYC.
    - The counter increments on each PASS cycle where the input is active and clears to 0 on red.
    - The counter saturates at MAX_ON_CYC.
- FLASH:
  - A phase counter runs 0..FLASH_HALF-1.
  - The phase starts "on" (all drv = 100) and toggles to "off" (all drv = 000) on each wrap.
  - Inputs are ignored; watchdog counters are held at 0.
  - fault_clr = 1 → RECOVER at the next edge with all drv = 100, counter reset.
- RECOVER:
  - All drv = 100 for ALLRED_CYC cycles; fault_clr is ignored.
  - On the final cycle, inputs are checked with the previous value taken as 100 for all approaches.
    - Pass → PASS; drv loads the inputs; fault and fault_code clear.
    - Fail → FLASH; fault_code takes the new code.
- Simultaneous events: fault_clr in PASS or RECOVER has no effect. Multiple failing checks record the lowest code only.
- Reset mid-FLASH or mid-RECOVER returns to the reset state immediately.

Optional Feature:
- Macro LFM_FAULT_COUNT_EN.
- Defined:
  - Adds output fault_count [7:0], an 8-bit counter, reset to 0.
  - Increments on every PASS→FLASH and RECOVER→FLASH transition; saturates at 255; unaffected by fault_clr.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package traffic_pkg holds:
  - light constants: LT_RED = 3'b100, LT_YEL = 3'b010, LT_GRN = 3'b001, LT_DARK = 3'b000;
  - fault code constants: FC_NONE = 0, FC_ENC = 1, FC_CONF = 2, FC_SEQ = 3, FC_STUCK = 4;
  - monitor state encoding: PASS, FLASH, RECOVER.
- Sub-module lamp_watchdog:
  - one per approach, 4 instances;
  - contains the active counter, the previous-light register, and the encoding/sequence/stuck checks for one approach;
  - outputs active, enc_err, seq_err, stuck.
- The top level does the conflict check, priority encode, FSM and flash timing.

Test Plan:
- Reset release, then M1 = M2 = 001 and S = MT = 100 → one cycle later drv matches; fault = 0.
- From that state, drive S = 001 for one cycle → next edge: all drv = 100, fault = 1, fault_code = 2; then drv alternates 100/000 every cycle.
- M1 goes 001→100 directly → fault_code = 3. Separately, M1 = 110 → fault_code = 1. Separately, M1 = 110 with S = 001 → fault_code = 1 (priority).
- Hold M1 = 001 for 60 cycles → stuck fault raised (fault_code = 4) at the edge after the 60th active cycle.
- Pulse fault_clr in FLASH with legal inputs → 3 cycles of all drv = 100, then pass-through with fault = 0. Repeat with S = 001 and M1 = 001 present at the end of recovery → returns to FLASH with fault_code = 2.
- Assert rst = 0 mid-RECOVER → drv = 100 and fault = 0 immediately, without waiting for a clock edge. With LFM_FAULT_COUNT_EN defined, fault_count counts 2 after the two faults above.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared light encodings, fault codes and monitor states for the lamp fault monitor.
// Lights are one-hot {red, yellow, green}; dark is only ever produced by the flash output.
package traffic_pkg;

    localparam logic [2:0] LT_RED  = 3'b100;
    localparam logic [2:0] LT_YEL  = 3'b010;
    localparam logic [2:0] LT_GRN  = 3'b001;
    localparam logic [2:0] LT_DARK = 3'b000;

    localparam logic [2:0] FC_NONE  = 3'd0;
    localparam logic [2:0] FC_ENC   = 3'd1;
    localparam logic [2:0] FC_CONF  = 3'd2;
    localparam logic [2:0] FC_SEQ   = 3'd3;
    localparam logic [2:0] FC_STUCK = 3'd4;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        FLASH   = 2'd1,
        RECOVER = 2'd2
    } mon_state_t;

    function automatic logic is_valid_light(input logic [2:0] l);
        return (l == LT_RED) || (l == LT_YEL) || (l == LT_GRN);
    endfunction

    // Holding is always legal; otherwise only the G->Y->R->G cycle is allowed.
    function automatic logic is_legal_step(input logic [2:0] prev, input logic [2:0] cur);
        return (cur == prev) ||
               ((prev == LT_GRN) && (cur == LT_YEL)) ||
               ((prev == LT_YEL) && (cur == LT_RED)) ||
               ((prev == LT_RED) && (cur == LT_GRN));
    endfunction

endpackage

// File: rtl/lamp_watchdog.sv
// Per-approach checker: encoding, sequence against the last accepted light, and
// a saturating consecutive-active counter that flags a stuck non-red lamp.
module lamp_watchdog
    import traffic_pkg::*;
#(
    parameter int MAX_ON_CYC = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    input  logic       prev_red,
    input  logic       count_en,
    input  logic       commit,
    input  logic       clear,
    output logic       active,
    output logic       enc_err,
    output logic       seq_err,
    output logic       stuck
);

    localparam int CW = $clog2(MAX_ON_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_ON_CYC);

    logic [CW-1:0] cnt;
    logic [2:0]    prev;
    logic [2:0]    prev_ref;

    assign prev_ref = prev_red ? LT_RED : prev;
    assign active   = (light != LT_RED);
    assign enc_err  = !is_valid_light(light);
    assign seq_err  = !enc_err && !is_legal_step(prev_ref, light);
    // Flags on the cycle that would carry the count up to the limit.
    assign stuck    = active && (cnt >= (CNT_MAX - CW'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            prev <= LT_RED;
        end else begin
            if (clear) begin
                cnt <= '0;
            end else if (count_en) begin
                if (!active) begin
                    cnt <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + CW'(1);
                end
            end
            if (commit) begin
                prev <= light;
            end else if (clear) begin
                prev <= LT_RED;
            end
        end
    end

endmodule

// File: rtl/light_fault_monitor.sv
// Lamp-driver front end: passes controller lights through while they are sane,
// otherwise latches a fault and flashes red until an operator clear and all-red recovery.
// Optional macro LFM_FAULT_COUNT_EN adds a saturating fault_count output.
//
//   state   | meaning
//   PASS    | checked inputs registered onto the lamp drives
//   FLASH   | fault latched, all drives flash red/dark, waiting for fault_clr
//   RECOVER | solid all-red interval, inputs re-checked on its last cycle
module light_fault_monitor
    import traffic_pkg::*;
#(
    parameter int MAX_ON_CYC = 60,
    parameter int FLASH_HALF = 1,
    parameter int ALLRED_CYC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_S,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic       fault_clr,
    output logic [2:0] drv_M1,
    output logic [2:0] drv_S,
    output logic [2:0] drv_M2,
    output logic [2:0] drv_MT,
    output logic       fault,
    output logic [2:0] fault_code
`ifdef LFM_FAULT_COUNT_EN
    ,
    output logic [7:0] fault_count
`endif
);

    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int RW = (ALLRED_CYC > 1) ? $clog2(ALLRED_CYC) : 1;
    localparam logic [FW-1:0] FLASH_LAST   = FW'(FLASH_HALF - 1);
    localparam logic [RW-1:0] RECOVER_LAST = RW'(ALLRED_CYC - 1);
    localparam logic [3:0][2:0] ALL_RED  = {4{LT_RED}};
    localparam logic [3:0][2:0] ALL_DARK = {4{LT_DARK}};

    mon_state_t      state, state_nxt;
    logic [3:0][2:0] light_vec;
    logic [3:0][2:0] drv_q, drv_nxt;
    logic [2:0]      code_q, code_nxt;
    logic [FW-1:0]   fcnt, fcnt_nxt;
    logic            phase_off, phase_nxt;
    logic [RW-1:0]   rcnt, rcnt_nxt;

    logic [3:0] active, enc_err, seq_err, stuck;
    logic       prev_red, count_en, commit, clear, to_flash;
    logic       conflict;
    logic [2:0] chk_code;

    // Index order: 0 = M1, 1 = S, 2 = M2, 3 = MT.
    assign light_vec = {light_MT, light_M2, light_S, light_M1};
    assign prev_red  = (state == RECOVER);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wd
            lamp_watchdog #(
                .MAX_ON_CYC(MAX_ON_CYC)
            ) u_wd (
                .clk      (clk),
                .rst      (rst),
                .light    (light_vec[gi]),
                .prev_red (prev_red),
                .count_en (count_en),
                .commit   (commit),
                .clear    (clear),
                .active   (active[gi]),
                .enc_err  (enc_err[gi]),
                .seq_err  (seq_err[gi]),
                .stuck    (stuck[gi])
            );
        end
    endgenerate

    // Side road excludes every main movement; opposing main and turn exclude each other.
    assign conflict = (active[1] && (active[0] || active[2] || active[3])) ||
                      (active[2] && active[3]);

    always_comb begin
        chk_code = FC_NONE;
        if (|enc_err) begin
            chk_code = FC_ENC;
        end else if (conflict) begin
            chk_code = FC_CONF;
        end else if (|seq_err) begin
            chk_code = FC_SEQ;
        end else if (|stuck) begin
            chk_code = FC_STUCK;
        end
    end

    always_comb begin
        state_nxt = state;
        drv_nxt   = drv_q;
        code_nxt  = code_q;
        fcnt_nxt  = fcnt;
        phase_nxt = phase_off;
        rcnt_nxt  = rcnt;
        count_en  = 1'b0;
        commit    = 1'b0;
        clear     = 1'b0;
        to_flash  = 1'b0;
        case (state)
            PASS: begin
                if (chk_code == FC_NONE) begin
                    drv_nxt  = light_vec;
                    count_en = 1'b1;
                    commit   = 1'b1;
                end else begin
                    to_flash = 1'b1;
                    clear    = 1'b1;
                end
            end
            FLASH: begin
                clear = 1'b1;
                if (fault_clr) begin
                    state_nxt = RECOVER;
                    drv_nxt   = ALL_RED;
                    rcnt_nxt  = '0;
                end else if (fcnt == FLASH_LAST) begin
                    fcnt_nxt  = '0;
                    phase_nxt = !phase_off;
                    drv_nxt   = phase_off ? ALL_RED : ALL_DARK;
                end else begin
                    fcnt_nxt = fcnt + FW'(1);
                end
            end
            RECOVER: begin
                clear = 1'b1;
                if (rcnt == RECOVER_LAST) begin
                    if (chk_code == FC_NONE) begin
                        state_nxt = PASS;
                        drv_nxt   = light_vec;
                        code_nxt  = FC_NONE;
                        commit    = 1'b1;
                    end else begin
                        to_flash = 1'b1;
                    end
                end else begin
                    rcnt_nxt = rcnt + RW'(1);
                end
            end
            default: begin
                state_nxt = PASS;
                drv_nxt   = ALL_RED;
                code_nxt  = FC_NONE;
            end
        endcase
        if (to_flash) begin
            state_nxt = FLASH;
            drv_nxt   = ALL_RED;
            code_nxt  = chk_code;
            fcnt_nxt  = '0;
            phase_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PASS;
            drv_q     <= ALL_RED;
            code_q    <= FC_NONE;
            fcnt      <= '0;
            phase_off <= 1'b0;
            rcnt      <= '0;
        end else begin
            state     <= state_nxt;
            drv_q     <= drv_nxt;
            code_q    <= code_nxt;
            fcnt      <= fcnt_nxt;
            phase_off <= phase_nxt;
            rcnt      <= rcnt_nxt;
        end
    end

    assign drv_M1     = drv_q[0];
    assign drv_S      = drv_q[1];
    assign drv_M2     = drv_q[2];
    assign drv_MT     = drv_q[3];
    assign fault      = (state != PASS);
    assign fault_code = code_q;

`ifdef LFM_FAULT_COUNT_EN
    logic [7:0] fcount_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcount_q <= 8'd0;
        end else if (to_flash && (fcount_q != 8'hFF)) begin
            fcount_q <= fcount_q + 8'd1;
        end
    end

    assign fault_count = fcount_q;
`endif

endmodule

// File: tb/tb_light_fault_monitor.sv
// Self-checking bench for light_fault_monitor: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a rule-level model.
module tb_light_fault_monitor;

    localparam int MAX_ON_CYC = 60;
    localparam int FLASH_HALF = 1;
    localparam int ALLRED_CYC = 3;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk;
    logic       rst;
    logic [2:0] lin [4];
    logic       fault_clr;
    logic [2:0] drv_M1, drv_S, drv_M2, drv_MT;
    logic       fault;
    logic [2:0] fault_code;
`ifdef LFM_FAULT_COUNT_EN
    logic [7:0] fault_count;
`endif

    light_fault_monitor #(
        .MAX_ON_CYC(MAX_ON_CYC),
        .FLASH_HALF(FLASH_HALF),
        .ALLRED_CYC(ALLRED_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .light_M1   (lin[0]),
        .light_S    (lin[1]),
        .light_M2   (lin[2]),
        .light_MT   (lin[3]),
        .fault_clr  (fault_clr),
        .drv_M1     (drv_M1),
        .drv_S      (drv_S),
        .drv_M2     (drv_M2),
        .drv_MT     (drv_MT),
        .fault      (fault),
        .fault_code (fault_code)
`ifdef LFM_FAULT_COUNT_EN
        ,
        .fault_count(fault_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = passing, 1 = flashing, 2 = all-red recovery
    int         m_mode;
    int         m_since;
    logic [2:0] m_drv  [4];
    logic [2:0] m_prev [4];
    int         m_run  [4];
    logic [2:0] m_code;
    int         m_cnt;

    function automatic int eval_code(input logic [2:0] l[4], input logic [2:0] pv[4], input int rn[4]);
        bit act [4];
        for (int i = 0; i < 4; i++)
            if (!(l[i] == R || l[i] == Y || l[i] == G)) return 1;
        for (int i = 0; i < 4; i++) act[i] = (l[i] != R);
        if (act[1] && (act[0] || act[2] || act[3])) return 2;
        if (act[2] && act[3]) return 2;
        for (int i = 0; i < 4; i++) begin
            if (!(l[i] == pv[i] || (pv[i] == G && l[i] == Y) ||
                  (pv[i] == Y && l[i] == R) || (pv[i] == R && l[i] == G))) return 3;
        end
        for (int i = 0; i < 4; i++)
            if (act[i] && (rn[i] + 1 >= MAX_ON_CYC)) return 4;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_since = 0; m_code = 3'd0; m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            m_drv[i] = R; m_prev[i] = R; m_run[i] = 0;
        end
    endtask

    task automatic model_enter_flash(input int c);
        m_mode = 1; m_since = 0; m_code = 3'(c);
        if (m_cnt < 255) m_cnt++;
        for (int i = 0; i < 4; i++) begin
            m_drv[i] = R; m_prev[i] = R; m_run[i] = 0;
        end
    endtask

    task automatic model_step();
        int         c;
        logic [2:0] red4 [4];
        int         zero4[4];
        case (m_mode)
            0: begin
                c = eval_code(lin, m_prev, m_run);
                if (c == 0) begin
                    for (int i = 0; i < 4; i++) begin
                        m_drv[i]  = lin[i];
                        m_prev[i] = lin[i];
                        m_run[i]  = (lin[i] != R) ? ((m_run[i] < MAX_ON_CYC) ? m_run[i] + 1 : m_run[i]) : 0;
                    end
                end else begin
                    model_enter_flash(c);
                end
            end
            1: begin
                if (fault_clr) begin
                    m_mode = 2; m_since = 0;
                    for (int i = 0; i < 4; i++) m_drv[i] = R;
                end else begin
                    m_since++;
                    for (int i = 0; i < 4; i++) m_drv[i] = (((m_since / FLASH_HALF) % 2) != 0) ? 3'b000 : R;
                end
            end
            default: begin
                if (m_since == ALLRED_CYC - 1) begin
                    for (int i = 0; i < 4; i++) begin red4[i] = R; zero4[i] = 0; end
                    c = eval_code(lin, red4, zero4);
                    if (c == 0) begin
                        m_mode = 0; m_code = 3'd0;
                        for (int i = 0; i < 4; i++) begin
                            m_drv[i] = lin[i]; m_prev[i] = lin[i]; m_run[i] = 0;
                        end
                    end else begin
                        model_enter_flash(c);
                    end
                end else begin
                    m_since++;
                end
            end
        endcase
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            chk("m_drv_M1", drv_M1, m_drv[0]);
            chk("m_drv_S",  drv_S,  m_drv[1]);
            chk("m_drv_M2", drv_M2, m_drv[2]);
            chk("m_drv_MT", drv_MT, m_drv[3]);
            chk("m_fault",  fault,  (m_mode != 0));
            chk("m_code",   fault_code, m_code);
`ifdef LFM_FAULT_COUNT_EN
            chk("m_count",  fault_count, m_cnt);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_lights(input logic [2:0] m1, input logic [2:0] s,
                              input logic [2:0] m2, input logic [2:0] mt);
        lin[0] = m1; lin[1] = s; lin[2] = m2; lin[3] = mt;
    endtask

    task automatic do_recover();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        tick();
        tick();
        tick();
    endtask

    function automatic logic [2:0] next_legal(input logic [2:0] l);
        case (l)
            R:       return G;
            G:       return Y;
            default: return R;
        endcase
    endfunction

    initial begin
        int r, a;
        rst = 1'b0;
        fault_clr = 1'b0;
        set_lights(R, R, R, R);
        tick();
        tick();
        chk("rst_drv_M1", drv_M1, 3'b100);
        chk("rst_drv_MT", drv_MT, 3'b100);
        chk("rst_fault",  fault,  1'b0);
        chk("rst_code",   fault_code, 3'd0);

        set_lights(G, R, G, R);
        rst = 1'b1;
        tick();
        chk("pass_M1", drv_M1, 3'b001);
        chk("pass_M2", drv_M2, 3'b001);
        chk("pass_S",  drv_S,  3'b100);
        chk("pass_fault", fault, 1'b0);

        lin[1] = G;
        tick();
        chk("conf_M1",    drv_M1, 3'b100);
        chk("conf_S",     drv_S,  3'b100);
        chk("conf_fault", fault,  1'b1);
        chk("conf_code",  fault_code, 3'd2);
        lin[1] = R;
        tick();
        chk("flash_off", drv_M1, 3'b000);
        tick();
        chk("flash_on",  drv_M1, 3'b100);

        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("rec_red0", drv_M1, 3'b100);
        tick();
        tick();
        chk("rec_red2",   drv_M2, 3'b100);
        chk("rec_fault2", fault,  1'b1);
        tick();
        chk("rec_pass_M1",    drv_M1, 3'b001);
        chk("rec_pass_fault", fault,  1'b0);

        lin[0] = R;
        tick();
        chk("seq_code", fault_code, 3'd3);
        lin[0] = G;
        do_recover();
        chk("seq_recovered", fault, 1'b0);

        lin[0] = 3'b110;
        tick();
        chk("enc_code", fault_code, 3'd1);
        lin[0] = G;
        do_recover();

        lin[0] = 3'b110;
        lin[1] = G;
        tick();
        chk("prio_code", fault_code, 3'd1);
        lin[0] = G;
        lin[1] = R;
        do_recover();

        lin[1] = G;
        tick();
        chk("conf2_code", fault_code, 3'd2);
        do_recover();
        chk("rec_fail_fault", fault,  1'b1);
        chk("rec_fail_code",  fault_code, 3'd2);
        chk("rec_fail_drv",   drv_M1, 3'b100);
        lin[1] = R;

        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        tick();
        #1 rst = 1'b0;
        #1;
        chk("async_fault", fault,  1'b0);
        chk("async_drv",   drv_S,  3'b100);
        chk("async_code",  fault_code, 3'd0);

        set_lights(G, R, R, R);
        tick();
        rst = 1'b1;
        for (int k = 0; k < MAX_ON_CYC - 1; k++) tick();
        chk("stuck_pre_fault", fault,  1'b0);
        chk("stuck_pre_drv",   drv_M1, 3'b001);
        tick();
        chk("stuck_fault", fault, 1'b1);
        chk("stuck_code",  fault_code, 3'd4);

        rst = 1'b0;
        set_lights(R, R, R, R);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                a = $urandom_range(0, 3);
                lin[a] = next_legal(lin[a]);
            end else if (r < 14) begin
                a = $urandom_range(0, 3);
                lin[a] = 3'($urandom_range(0, 7));
            end
            fault_clr = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 999) < 3) begin
                #1 rst = 1'b0;
                #1 rst = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
